// File: rtl/fare_meter_pkg.sv
// Shared state encoding, display constants and default tariff for the fare meter.
// The saturating adder keeps every price update from wrapping past the display limit.
package fare_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [5:0] POINT_MASK = 6'b000100;

  localparam int unsigned DEF_DEBOUNCE_CYC = 999_999;
  localparam int unsigned DEF_M_PER_PULSE  = 1;
  localparam int unsigned DEF_BASE_FARE    = 1000;
  localparam int unsigned DEF_BASE_DIST    = 3000;
  localparam int unsigned DEF_STEP_FEE     = 20;
  localparam logic [31:0] DEF_MIN_CYC      = 32'd3_000_000_000;
  localparam int unsigned DEF_LOW_PULSES   = 50;
  localparam int unsigned DEF_WAIT_FEE     = 50;
  localparam int unsigned DEF_PRICE_MAX    = 999_999;

  function automatic logic [19:0] sat_add20(input logic [19:0] a,
                                            input logic [19:0] b,
                                            input logic [19:0] lim);
    logic [20:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[19:0];
  endfunction

endpackage

// File: rtl/fare_meter_core_key_debounce.sv
// Trip key conditioner: 2-FF synchroniser, stability counter and a one-cycle pulse
// on each debounced press (high-to-low transition of the active-low key).
module key_debounce #(
  parameter int unsigned STABLE_CYC = 999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_evt
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [1:0]    sync_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;

  // The counter only runs while the synchronised level disagrees with the accepted one,
  // so any glitch shorter than STABLE_CYC restarts it from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg   <= 2'b11;
      stable_reg <= 1'b1;
      cnt_reg    <= '0;
      key_evt    <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], key_raw};
      key_evt  <= 1'b0;
      if (sync_reg[1] == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(STABLE_CYC - 1)) begin
        cnt_reg    <= '0;
        stable_reg <= sync_reg[1];
        key_evt    <= stable_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fare_meter_core.sv
// Fare engine: wheel-pulse distance, waiting-minute timer and trip FSM producing the
// displayed price in fen plus display enables and status LEDs.
module fare_meter_core
  import fare_meter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned M_PER_PULSE  = DEF_M_PER_PULSE,
  parameter int unsigned BASE_FARE    = DEF_BASE_FARE,
  parameter int unsigned BASE_DIST    = DEF_BASE_DIST,
  parameter int unsigned STEP_FEE     = DEF_STEP_FEE,
  parameter logic [31:0] MIN_CYC      = DEF_MIN_CYC,
  parameter int unsigned LOW_PULSES   = DEF_LOW_PULSES,
  parameter int unsigned WAIT_FEE     = DEF_WAIT_FEE,
  parameter int unsigned PRICE_MAX    = DEF_PRICE_MAX
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pulse_port,
  input  logic        stat_port,
  output logic [19:0] price,
  output logic [5:0]  point,
  output logic        seg_en,
  output logic        sign,
  output logic        stat_led,
  output logic        dist_led
);

  localparam int PCW = $clog2(LOW_PULSES + 1);

  state_t          state_reg;
  logic [2:0]      wheel_sync_reg;
  logic [19:0]     dist_reg;
  logic [7:0]      m100_reg;
  logic            step_pend_reg;
  logic [31:0]     min_cnt_reg;
  logic [PCW-1:0]  pulse_cnt_reg;

  logic            key_evt;
  logic            pulse_evt;
  logic [7:0]      m100_sum;
  logic [20:0]     dist_sum;
  logic [19:0]     dist_inc;
  logic            minute_wrap;
  logic            wait_hit;
  logic [19:0]     step_add;
  logic [19:0]     fee_add;

  key_debounce #(
    .STABLE_CYC (DEBOUNCE_CYC)
  ) u_key (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .key_raw (stat_port),
    .key_evt (key_evt)
  );

  assign point     = POINT_MASK;
  assign sign      = 1'b0;
  // Bits [1:0] synchronise the pin; bit [2] remembers the previous synced level.
  assign pulse_evt = wheel_sync_reg[1] & ~wheel_sync_reg[2];

  always_comb begin
    m100_sum    = m100_reg + (pulse_evt ? 8'(M_PER_PULSE) : 8'd0);
    dist_sum    = {1'b0, dist_reg} + 21'(M_PER_PULSE);
    dist_inc    = dist_sum[20] ? 20'hFFFFF : dist_sum[19:0];
    minute_wrap = (min_cnt_reg == MIN_CYC - 32'd1);
    wait_hit    = minute_wrap && (pulse_cnt_reg < PCW'(LOW_PULSES));
    step_add    = step_pend_reg ? 20'(STEP_FEE) : 20'd0;
    fee_add     = step_add + (wait_hit ? 20'(WAIT_FEE) : 20'd0);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wheel_sync_reg <= 3'b000;
    end else begin
      wheel_sync_reg <= {wheel_sync_reg[1:0], pulse_port};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_reg     <= ST_IDLE;
      price         <= '0;
      seg_en        <= 1'b0;
      stat_led      <= 1'b0;
      dist_led      <= 1'b0;
      dist_reg      <= '0;
      m100_reg      <= '0;
      step_pend_reg <= 1'b0;
      min_cnt_reg   <= '0;
      pulse_cnt_reg <= '0;
    end else begin
      step_pend_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (key_evt) begin
            state_reg     <= ST_RUN;
            price         <= 20'(BASE_FARE);
            seg_en        <= 1'b1;
            stat_led      <= 1'b1;
            dist_reg      <= '0;
            m100_reg      <= '0;
            min_cnt_reg   <= '0;
            pulse_cnt_reg <= '0;
          end
        end
        ST_RUN: begin
          if (pulse_evt) begin
            dist_reg <= dist_inc;
          end
          // A completed 100 m is charged on the next cycle via step_pend_reg.
          if (m100_sum >= 8'd100) begin
            m100_reg      <= m100_sum - 8'd100;
            dist_led      <= ~dist_led;
            step_pend_reg <= (dist_inc > 20'(BASE_DIST));
          end else begin
            m100_reg <= m100_sum;
          end
          if (minute_wrap) begin
            min_cnt_reg   <= '0;
            pulse_cnt_reg <= PCW'(pulse_evt);
          end else begin
            min_cnt_reg <= min_cnt_reg + 32'd1;
            if (pulse_evt && (pulse_cnt_reg != PCW'(LOW_PULSES))) begin
              pulse_cnt_reg <= pulse_cnt_reg + PCW'(1);
            end
          end
          price <= sat_add20(price, fee_add, 20'(PRICE_MAX));
          if (key_evt) begin
            state_reg <= ST_HOLD;
            stat_led  <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Only a step charge already earned on the last RUN cycle may still land here.
          if (key_evt) begin
            state_reg <= ST_IDLE;
            price     <= '0;
            seg_en    <= 1'b0;
          end else begin
            price <= sat_add20(price, step_add, 20'(PRICE_MAX));
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          price     <= '0;
          seg_en    <= 1'b0;
          stat_led  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fare_meter_core.sv
// Directed-plus-random bench for fare_meter_core with a minute/pulse ledger model of the tariff.
module tb_fare_meter_core;

  localparam int MIN_T    = 1000;
  localparam int LOW_T    = 5;
  localparam int BASE     = 1000;
  localparam int STEP     = 20;
  localparam int WAITF    = 50;
  localparam int PMAX     = 999_999;
  localparam int SAT_BASE = 999_900;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pulse_in, key_in;
  logic [19:0] price;
  logic [5:0]  point;
  logic        seg_en, sign, stat_led, dist_led;

  logic        rst_b_n, key_b;
  logic [19:0] price_b;
  logic [5:0]  point_b;
  logic        seg_en_b, sign_b, stat_led_b, dist_led_b;

  fare_meter_core #(.DEBOUNCE_CYC(10), .MIN_CYC(32'd1000), .LOW_PULSES(5)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .pulse_port(pulse_in), .stat_port(key_in),
    .price(price), .point(point), .seg_en(seg_en), .sign(sign),
    .stat_led(stat_led), .dist_led(dist_led)
  );

  fare_meter_core #(.DEBOUNCE_CYC(10), .MIN_CYC(32'd1000), .LOW_PULSES(5),
                    .BASE_FARE(SAT_BASE)) dut_sat (
    .sys_clk(clk), .sys_rst_n(rst_b_n), .pulse_port(1'b0), .stat_port(key_b),
    .price(price_b), .point(point_b), .seg_en(seg_en_b), .sign(sign_b),
    .stat_led(stat_led_b), .dist_led(dist_led_b)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference ledger: pulses per trip minute, trip distance, fees earned, led toggles.
  int mp [32];
  int dist_m      = 0;
  int step_fees   = 0;
  int led_toggles = 0;
  int run_start   = 0;

  int   mon_toggles = 0;
  logic led_prev    = 1'b0;
  always @(posedge clk) begin
    #1;
    if (dist_led !== led_prev) mon_toggles++;
    led_prev = dist_led;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int rel();
    return int'(cyc) - run_start;
  endfunction

  function automatic int exp_price(input int k);
    int f = 0;
    int p;
    for (int j = 0; j < k / MIN_T && j < 32; j++) if (mp[j] < LOW_T) f++;
    p = BASE + STEP * step_fees + WAITF * f;
    return (p > PMAX) ? PMAX : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_trip();
    for (int j = 0; j < 32; j++) mp[j] = 0;
    dist_m    = 0;
    step_fees = 0;
  endtask

  // One wheel pulse: 2 cycles high, 2 low; its event lands about 3 edges after the rise.
  task automatic wheel_pulse(input bit counted);
    int m;
    if (counted) begin
      m = (rel() + 3) / MIN_T;
      if (m < 32) mp[m]++;
      dist_m++;
      if (dist_m % 100 == 0) begin
        led_toggles++;
        if (dist_m > 3000) step_fees++;
      end
    end
    pulse_in = 1'b1;
    tick(2);
    pulse_in = 1'b0;
    tick(2);
  endtask

  task automatic press_main(output bit seen_run);
    seen_run = 1'b0;
    key_in   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!seen_run && stat_led === 1'b1) begin
        seen_run  = 1'b1;
        run_start = int'(cyc);
      end
    end
    key_in = 1'b1;
    tick(20);
  endtask

  initial begin
    bit seen;
    int exp_hold;
    int sat_start;

    rst_n = 1'b0; rst_b_n = 1'b0; key_in = 1'b1; key_b = 1'b1; pulse_in = 1'b0;
    clear_trip();
    tick(5);
    chk("rst_price", price, 0);
    chk("rst_seg_en", seg_en, 0);
    chk("rst_stat_led", stat_led, 0);
    chk("rst_dist_led", dist_led, 0);
    chk("rst_point", point, 6'b000100);
    chk("rst_sign", sign, 0);
    rst_n = 1'b1; rst_b_n = 1'b1;
    tick(3);

    repeat (6) begin
      key_in = 1'b0; tick(5);
      key_in = 1'b1; tick(5);
    end
    tick(20);
    chk("bounce_stat_led", stat_led, 0);
    chk("bounce_price", price, 0);
    chk("bounce_seg_en", seg_en, 0);

    press_main(seen);
    chk("run_seen", seen, 1);
    chk("run_price", price, exp_price(rel()));
    chk("run_stat_led", stat_led, 1);
    chk("run_seg_en", seg_en, 1);

    while (rel() < 2050) tick(1);
    chk("idle_wait_price", price, exp_price(rel()));

    for (int j = 2; j < 7; j++) begin
      int n;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(20, 40));
      while (rel() < j * MIN_T + 50) tick(1);
      for (int p = 0; p < n; p++) begin
        tick(int'($urandom_range(0, 6)));
        wheel_pulse(1'b1);
      end
      while (rel() < (j + 1) * MIN_T + 20) tick(1);
      chk($sformatf("min%0d_n%0d_price", j, n), price, exp_price(rel()));
      chk($sformatf("min%0d_dist_led", j), dist_led, led_toggles % 2);
    end

    exp_hold = exp_price(rel());
    press_main(seen);
    chk("hold_stat_led", stat_led, 0);
    chk("hold_seg_en", seg_en, 1);
    chk("hold_price", price, exp_hold);
    for (int p = 0; p < 150; p++) wheel_pulse(1'b0);
    tick(1000);
    chk("hold_frozen_price", price, exp_hold);
    chk("hold_dist_led", dist_led, led_toggles % 2);

    press_main(seen);
    chk("idle_price", price, 0);
    chk("idle_seg_en", seg_en, 0);
    chk("idle_stat_led", stat_led, 0);

    clear_trip();
    mon_toggles = 0;
    press_main(seen);
    chk("trip2_seen", seen, 1);
    for (int p = 0; p < 3100; p++) begin
      while (((rel() + 3) % MIN_T) < 6 || ((rel() + 3) % MIN_T) >= 994) tick(1);
      wheel_pulse(1'b1);
    end
    tick(6);
    while ((rel() % MIN_T) < 10 || (rel() % MIN_T) > 980) tick(1);
    chk("fast_toggles", mon_toggles, 31);
    chk("fast_price", price, exp_price(rel()));
    chk("fast_dist_led", dist_led, led_toggles % 2);

    rst_n = 1'b0;
    tick(1);
    chk("midrst_price", price, 0);
    chk("midrst_stat_led", stat_led, 0);
    chk("midrst_dist_led", dist_led, 0);
    chk("midrst_seg_en", seg_en, 0);
    rst_n = 1'b1;
    tick(3);

    seen = 1'b0;
    sat_start = 0;
    key_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!seen && stat_led_b === 1'b1) begin
        seen = 1'b1;
        sat_start = int'(cyc);
      end
    end
    key_b = 1'b1;
    chk("sat_seen", seen, 1);
    while (int'(cyc) - sat_start < 1500) tick(1);
    chk("sat_mid_price", price_b, (SAT_BASE + WAITF > PMAX) ? PMAX : SAT_BASE + WAITF);
    while (int'(cyc) - sat_start < 3500) tick(1);
    chk("sat_hold_price", price_b, (SAT_BASE + 3 * WAITF > PMAX) ? PMAX : SAT_BASE + 3 * WAITF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
